// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   b_q, b_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic              a_signed, b_signed, a_neg, b_neg, neg_start;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, ovf, fast;
  logic [XLEN-1:0]   fast_val;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_s;
  logic [XLEN+1:0]   div_sh, div_diff;
  logic              div_ok;
  logic [XLEN:0]     rem_next;
  logic [XLEN-1:0]   q_next, q_s, r_s, mul_res, calc_res;
  assign a_signed  = (funct3 == 3'd1) | (funct3 == 3'd2) | (funct3 == 3'd4) | (funct3 == 3'd6);
  assign b_signed  = (funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6);
  assign a_neg     = a_signed & rs1[XLEN-1];
  assign b_neg     = b_signed & rs2[XLEN-1];
  assign a_mag     = a_neg ? -rs1 : rs1;
  assign b_mag     = b_neg ? -rs2 : rs2;
  assign neg_start = (funct3 == 3'd6) ? a_neg : a_neg ^ b_neg;
  assign div_zero  = funct3[2] && (rs2 == '0);
  assign ovf       = funct3[2] && !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
  assign fast      = div_zero | ovf;
  assign fast_val  = div_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_sh    = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_sh - {2'b00, b_q};
  assign div_ok    = !div_diff[XLEN+1];
  assign rem_next  = div_ok ? div_diff[XLEN:0] : div_sh[XLEN:0];
  assign q_next    = {acc_q[XLEN-2:0], div_ok};
  assign prod_s    = neg_q ? -mul_next : mul_next;
  assign q_s       = neg_q ? -q_next : q_next;
  assign r_s       = neg_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
  assign mul_res   = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  assign calc_res  = !op_q[2] ? mul_res : (op_q[1] ? r_s : q_s);
  assign stall_req = !reset && !flush && ((state_q == IDLE && start) || state_q == CALC);
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE && !flush;
  assign result    = result_q;
  // Next-state: launch or fast-path from IDLE, one shift-add/restoring step per CALC cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start && !flush) begin
        if (fast) begin
          result_d = fast_val;
          state_d  = DONE;
        end else begin
          acc_d   = {{XLEN{1'b0}}, a_mag};
          b_d     = b_mag;
          rem_d   = '0;
          op_d    = funct3;
          neg_d   = neg_start;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: if (flush) begin
        state_d = IDLE;
      end else begin
        acc_d = op_q[2] ? {acc_q[2*XLEN-1:XLEN], q_next} : mul_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          result_d = calc_res;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset, start, flush, stall_req, busy, done;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, result;
  int checks = 0;
  int failures = 0;
  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Called #1 after a rising edge with the FSM idle; returns #1 into the idle cycle after done
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_cyc, input string tag);
    int dc;
    logic stall_ok;
    logic [31:0] res;
    dc = -1;
    stall_ok = 1'b1;
    res = '0;
    funct3 = f;
    rs1 = a;
    rs2 = b;
    start = 1'b1;
    for (int c = 0; c < 60 && dc < 0; c++) begin
      @(negedge clk);
      if (stall_req !== (c < exp_cyc)) stall_ok = 1'b0;
      if (done === 1'b1) begin
        dc = c;
        res = result;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, 32'(dc), 32'(exp_cyc));
    chk({tag, " result"}, res, exp_res);
    chk({tag, " stall_profile"}, 32'(stall_ok), 32'd1);
  endtask
  initial begin
    logic saw_done;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    funct3 = '0;
    rs1 = '0;
    rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset stall_req", 32'(stall_req), 32'd0);
    chk("reset result", result, 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh");
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, "mulhsu");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");
    funct3 = 3'd0;
    rs1 = 32'd3;
    rs2 = 32'd5;
    start = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (done === 1'b1) saw_done = 1'b1;
    chk("flush stall_req", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    if (done === 1'b1) saw_done = 1'b1;
    chk("flush idle", 32'(busy), 32'd0);
    chk("flush no_done", 32'(saw_done), 32'd0);
    chk("flush result_kept", result, 32'd2);
    @(posedge clk);
    #1;
    do_op(3'd0, 32'd3, 32'd5, 32'd15, 33, "mul_after_flush");
    do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    do_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    @(negedge clk);
    chk("result_hold", result, 32'h8000_0000);
    @(posedge clk);
    #1;
    funct3 = 3'd0;
    rs1 = 32'd7;
    rs2 = 32'd9;
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("midcalc busy", 32'(busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset busy", 32'(busy), 32'd0);
    chk("async_reset stall_req", 32'(stall_req), 32'd0);
    chk("async_reset done", 32'(done), 32'd0);
    chk("async_reset result", result, 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    do_op(3'd5, 32'd9, 32'd3, 32'd3, 33, "divu_after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
